reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
- Initiator side of the register bus (avalid/awe/aaddr/adata -> bvalid/bdata) that peripheral handlers such as the SDRAM handler respond on.
- Parses a host byte-command stream (from the USB endpoint FIFO) into single register transactions.
- Returns read data and status as a byte stream to the host TX FIFO.
- One outstanding transaction at a time; bvalid from all responders is OR-combined externally.

Parameters:
AW, 7, register word-address width (1..7; taken from opcode bits [AW-1:0])
TIMEOUT, 255, max cycles to wait for bvalid after issuing avalid (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  command byte from host
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte consumed when rx_valid && rx_ready
tx_data  out  8  response byte to host
tx_valid  out  1  tx_data valid
tx_ready  in  1  byte taken when tx_valid && tx_ready
avalid  out  1  bus request strobe, exactly one cycle
awe  out  1  1 = write, 0 = read; meaningful while avalid
aaddr  out  AW  word address
adata  out  32  write data
bvalid  in  1  response strobe from responder
bdata  in  32  read data, valid with bvalid

Behaviour:
- Reset (async, rst_n low): state IDLE; rx_ready=0 until first clock after release; tx_valid=0, avalid=0, awe=0, aaddr=0, adata=0, tx_data=0; counters cleared. Reset mid-transaction abandons it silently; no response byte is emitted.
- Command format: opcode byte, bit7 = write, bits[AW-1:0] = address, bits[6:AW] ignored.
  - Write: opcode followed by 4 data bytes, little-endian (first byte -> adata[7:0]).
  - Read: opcode alone.
- States:
  - IDLE: rx_ready=1. On opcode accept, latch awe and aaddr. Write -> WDATA with byte index 0. Read -> ISSUE.
  - WDATA: rx_ready=1. Each accepted byte fills adata[8*i+:8], i increments. After the 4th byte -> ISSUE. rx_valid gaps are allowed; no timeout here.
  - ISSUE: avalid=1 for exactly this cycle; awe/aaddr/adata stable. Next state WAIT, timeout counter=0.
  - WAIT: counter increments each cycle.
    - bvalid=1: capture bdata (reads), status=0x00, -> RESP.
    - Otherwise, counter reaching TIMEOUT-1 without bvalid: read data forced to 0xFFFFFFFF, status=0x01, -> RESP.
    - bvalid on the same cycle as the timeout takes priority (status 0x00).
  - RESP: tx_valid=1.
    - Read emits 5 bytes: data[7:0], [15:8], [23:16], [31:24], status.
    - Write emits 1 byte: status.
    - Advance only on tx_valid && tx_ready; tx_data stable while stalled. After the last byte -> IDLE.
- rx_ready=0 in ISSUE/WAIT/RESP. Earliest next opcode accept is the cycle after the last response byte is taken.
- Latency: the earliest bvalid is the cycle after avalid (responders register bvalid<=avalid). Minimum read round trip from opcode accept to first tx_valid is 3 cycles.
- bvalid outside WAIT (including during ISSUE) is ignored.
- A late bvalid from a timed-out transaction arriving in a later WAIT is accepted as that transaction's response; this is a system error and is not detected.
- awe/aaddr/adata hold their last values outside ISSUE. Responders qualify them with avalid only.
- Timeout counter width is clog2(TIMEOUT+1); no wrap inside WAIT.

Test Plan:
- Write: rx 0x81,78,56,34,12; bvalid one cycle after avalid -> single-cycle avalid with awe=1, aaddr=1, adata=0x12345678; tx emits 0x00 only.
- Read: rx 0x00; bvalid next cycle with bdata=0xA5000123 -> avalid with awe=0, aaddr=0; tx emits 23,01,00,A5,00; rx_ready low until the final byte is taken.
- Timeout (TIMEOUT=15): rx 0x01, no bvalid -> after 15 WAIT cycles, tx emits FF,FF,FF,FF,01; a later bvalid in IDLE is ignored and emits no bytes.
- Backpressure: read response with tx_ready toggling 1-0-0-1 -> tx_data held while stalled; no bytes lost or duplicated.
- Reset mid-WDATA (after 2 data bytes), then release and send a full read -> no avalid for the aborted write; the read completes normally.
- Gapped rx: write bytes with rx_valid low 3 cycles between each -> adata assembled correctly; one avalid pulse.

Source files
------------

// File: rtl/reg_bus_master.sv
// -----------------------------------------------------------------------------
// reg_bus_master
//   Initiator side of the register bus. Parses a host byte-command stream into
//   single register transactions and returns read data plus a status byte.
//
//   Command format: opcode byte, bit7 = write, bits[AW-1:0] = word address.
//     write: opcode + 4 data bytes, little-endian
//     read : opcode alone
//   Response: read -> data[7:0], [15:8], [23:16], [31:24], status
//             write -> status
//   Status 0x00 = responder answered, 0x01 = timed out (read data 0xFFFFFFFF).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data/valid/ready command byte stream from host
//   tx_data/valid/ready response byte stream to host
//   avalid/awe/aaddr/adata  bus request (avalid is a single-cycle strobe)
//   bvalid/bdata        OR-combined responder strobe and read data
// -----------------------------------------------------------------------------
module reg_bus_master #(
    parameter int AW      = 7,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          avalid,
    output logic          awe,
    output logic [AW-1:0] aaddr,
    output logic [31:0]   adata,
    input  logic          bvalid,
    input  logic [31:0]   bdata
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  TMO_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state_q;
    logic            rx_ready_q;
    logic            tx_valid_q;
    logic [7:0]      tx_data_q;
    logic            avalid_q;
    logic            awe_q;
    logic [AW-1:0]   aaddr_q;
    logic [31:0]     adata_q;
    logic [1:0]      wbyte_q;   // index of next write data byte
    logic [CW-1:0]   tmo_q;     // cycles spent in WAIT
    logic [39:0]     resp_q;    // response bytes, next byte to send at [15:8]
    logic [2:0]      rbytes_q;  // bytes still to send after the current one

    logic            rx_fire_s;
    logic            tx_fire_s;
    logic            wait_done_s;
    logic [31:0]     rd_word_s;
    logic [7:0]      status_s;
    logic [39:0]     resp_word_s;

    assign rx_fire_s   = rx_valid && rx_ready_q;
    assign tx_fire_s   = tx_valid_q && tx_ready;
    // bvalid is checked first so an answer on the last WAIT cycle beats the timeout
    assign wait_done_s = bvalid || (tmo_q == TMO_LAST);

    // Response word assembled from the bus result of the current WAIT cycle
    always_comb begin
        rd_word_s   = 32'hFFFF_FFFF;
        status_s    = 8'h01;
        resp_word_s = 40'h00_0000_0000;
        if (bvalid) begin
            rd_word_s = bdata;
            status_s  = 8'h00;
        end else begin
            rd_word_s = 32'hFFFF_FFFF;
            status_s  = 8'h01;
        end
        if (awe_q) begin
            resp_word_s = {32'h0000_0000, status_s};
        end else begin
            resp_word_s = {status_s, rd_word_s};
        end
    end

    // Command parser, bus sequencer and response serializer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            avalid_q   <= 1'b0;
            awe_q      <= 1'b0;
            aaddr_q    <= {AW{1'b0}};
            adata_q    <= 32'h0000_0000;
            wbyte_q    <= 2'd0;
            tmo_q      <= {CW{1'b0}};
            resp_q     <= 40'h00_0000_0000;
            rbytes_q   <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire_s) begin
                        awe_q   <= rx_data[7];
                        aaddr_q <= rx_data[AW-1:0];
                        wbyte_q <= 2'd0;
                        if (rx_data[7]) begin
                            state_q <= S_WDATA;
                        end else begin
                            state_q    <= S_ISSUE;
                            rx_ready_q <= 1'b0;
                            avalid_q   <= 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_fire_s) begin
                        adata_q[{wbyte_q, 3'b000} +: 8] <= rx_data;
                        wbyte_q <= wbyte_q + 2'd1;
                        if (wbyte_q == 2'd3) begin
                            state_q    <= S_ISSUE;
                            rx_ready_q <= 1'b0;
                            avalid_q   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // avalid was raised on entry, so it lives exactly this cycle
                    avalid_q <= 1'b0;
                    tmo_q    <= {CW{1'b0}};
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_done_s) begin
                        resp_q     <= resp_word_s;
                        tx_data_q  <= resp_word_s[7:0];
                        tx_valid_q <= 1'b1;
                        rbytes_q   <= awe_q ? 3'd0 : 3'd4;
                        state_q    <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                S_RESP: begin
                    if (tx_fire_s) begin
                        if (rbytes_q == 3'd0) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            resp_q    <= resp_q >> 8;
                            tx_data_q <= resp_q[15:8];
                            rbytes_q  <= rbytes_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    rx_ready_q <= 1'b0;
                    tx_valid_q <= 1'b0;
                    avalid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready = rx_ready_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign avalid   = avalid_q;
    assign awe      = awe_q;
    assign aaddr    = aaddr_q;
    assign adata    = adata_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_master
//   Directed self-checking bench for reg_bus_master (AW=7, TIMEOUT=15).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reg_bus_master;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        avalid;
    logic        awe;
    logic [6:0]  aaddr;
    logic [31:0] adata;
    logic        bvalid;
    logic [31:0] bdata;

    int n_assert = 0;
    int n_fail   = 0;
    int av_cnt   = 0;
    int av_before;
    logic av_prev  = 1'b0;
    logic av_multi = 1'b0;

    reg_bus_master #(.AW(7), .TIMEOUT(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .avalid   (avalid),
        .awe      (awe),
        .aaddr    (aaddr),
        .adata    (adata),
        .bvalid   (bvalid),
        .bdata    (bdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count avalid pulses and flag any pulse longer than one cycle
    always @(posedge clk) begin
        if (avalid === 1'b1) begin
            av_cnt = av_cnt + 1;
            if (av_prev === 1'b1) av_multi = 1'b1;
        end
        av_prev = avalid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted; called and returns at negedge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_accept_timeout", 64'(n), 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait for the avalid cycle and check the request fields there
    task automatic wait_issue(input string tag, input logic exp_awe, input logic [6:0] exp_addr,
                              input logic chk_data, input logic [31:0] exp_data);
        int n;
        n = 0;
        while (avalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_avalid"}, 64'(avalid), 64'd1);
        chk({tag, "_awe"}, 64'(awe), 64'(exp_awe));
        chk({tag, "_aaddr"}, 64'(aaddr), 64'(exp_addr));
        if (chk_data) chk({tag, "_adata"}, 64'(adata), 64'(exp_data));
    endtask

    // Registered-responder behaviour: bvalid high the cycle after avalid
    task automatic respond(input logic [31:0] d);
        @(negedge clk);
        bvalid = 1'b1;
        bdata  = d;
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    // Receive nexp bytes (byte k expected at exp40[8k+:8]) with tx_ready pattern pat
    task automatic collect(input string tag, input int nexp, input logic [39:0] exp40,
                           input logic [3:0] pat);
        int got, cyc, pi;
        logic [7:0] held;
        logic stalled;
        got = 0; cyc = 0; pi = 0; stalled = 1'b0; held = 8'h00;
        while (got < nexp && cyc < 100) begin
            if (tx_valid === 1'b1) begin
                chk({tag, "_rx_ready_low"}, 64'(rx_ready), 64'd0);
                if (stalled) chk({tag, "_hold"}, 64'(tx_data), 64'(held));
                tx_ready = pat[pi % 4];
                pi++;
                if (tx_ready) begin
                    chk($sformatf("%s_byte%0d", tag, got), 64'(tx_data), 64'(exp40[8*got +: 8]));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = tx_data;
                end
            end else begin
                tx_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        chk({tag, "_count"}, 64'(got), 64'(nexp));
        chk({tag, "_no_extra"}, 64'(tx_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(rx_ready), 64'd1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        bvalid   = 1'b0;
        bdata    = 32'h0000_0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_avalid", 64'(avalid), 64'd0);
        chk("rst_awe", 64'(awe), 64'd0);
        chk("rst_aaddr", 64'(aaddr), 64'd0);
        chk("rst_adata", 64'(adata), 64'd0);
        rst_n = 1'b1;
        chk("rel_rx_ready_before_clk", 64'(rx_ready), 64'd0);
        @(negedge clk);
        chk("rel_rx_ready_after_clk", 64'(rx_ready), 64'd1);

        // Write 0x12345678 to address 1
        send_byte(8'h81);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        wait_issue("wr1", 1'b1, 7'h01, 1'b1, 32'h1234_5678);
        respond(32'h0000_0000);
        collect("wr1_resp", 1, 40'h00_0000_0000, 4'b1111);

        // Read address 0, minimum latency
        send_byte(8'h00);
        chk("rd1_issue_next_cycle", 64'(avalid), 64'd1);
        wait_issue("rd1", 1'b0, 7'h00, 1'b0, 32'h0);
        respond(32'hA500_0123);
        chk("rd1_tx_latency", 64'(tx_valid), 64'd1);
        collect("rd1_resp", 5, 40'h00_A500_0123, 4'b1111);

        // Timeout on read of address 1
        send_byte(8'h01);
        wait_issue("tmo", 1'b0, 7'h01, 1'b0, 32'h0);
        n = 0;
        while (tx_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_wait_cycles", 64'(n), 64'd16);
        collect("tmo_resp", 5, 40'h01_FFFF_FFFF, 4'b1111);
        // Stray bvalid in IDLE must not produce anything
        bvalid = 1'b1;
        bdata  = 32'h5555_5555;
        @(negedge clk);
        bvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_bvalid_tx", 64'(tx_valid), 64'd0);
        chk("late_bvalid_rdy", 64'(rx_ready), 64'd1);

        // Backpressure on read response, tx_ready 1-0-0-1
        send_byte(8'h7F);
        wait_issue("bp", 1'b0, 7'h7F, 1'b0, 32'h0);
        respond(32'h1122_3344);
        collect("bp_resp", 5, 40'h00_1122_3344, 4'b1001);

        // bvalid on the last WAIT cycle wins over the timeout
        send_byte(8'h42);
        wait_issue("edge", 1'b0, 7'h42, 1'b0, 32'h0);
        repeat (15) @(negedge clk);
        chk("edge_no_early_tmo", 64'(tx_valid), 64'd0);
        bvalid = 1'b1;
        bdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bvalid = 1'b0;
        collect("edge_resp", 5, 40'h00_CAFE_F00D, 4'b1111);

        // Reset in the middle of write data, then a clean read
        send_byte(8'h83);
        send_byte(8'h11);
        send_byte(8'h22);
        av_before = av_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_adata", 64'(adata), 64'd0);
        chk("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_avalid", 64'(av_cnt), 64'(av_before));
        send_byte(8'h05);
        wait_issue("rst_rd", 1'b0, 7'h05, 1'b0, 32'h0);
        respond(32'h0BAD_F00D);
        collect("rst_rd_resp", 5, 40'h00_0BAD_F00D, 4'b1111);

        // Gapped write: rx_valid low 3 cycles between bytes
        send_byte(8'h8A);
        repeat (3) @(negedge clk);
        send_byte(8'hEF);
        repeat (3) @(negedge clk);
        send_byte(8'hBE);
        repeat (3) @(negedge clk);
        send_byte(8'hAD);
        repeat (3) @(negedge clk);
        send_byte(8'hDE);
        wait_issue("gap", 1'b1, 7'h0A, 1'b1, 32'hDEAD_BEEF);
        respond(32'h0000_0000);
        collect("gap_resp", 1, 40'h00_0000_0000, 4'b1111);

        repeat (2) @(negedge clk);
        chk("avalid_pulse_total", 64'(av_cnt), 64'd7);
        chk("avalid_single_cycle", 64'(av_multi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
